// File: rtl/sbox_build_ctrl.sv
// S-box build controller: issues chaotic-map draws to a byte generator, keeps
// first-seen bytes as table entries, then completes the permutation with an ascending fill.
module sbox_build_ctrl #(
   parameter int unsigned PRECISION = 32,
   parameter int unsigned MAX_DRAWS = 4096,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 prn_valid,
   input  logic [PRECISION-1:0] prn1,
   input  logic [PRECISION-1:0] prn2,
   input  logic [PRECISION-1:0] prn3,
   output logic                 gen_tvalid,
   output logic [PRECISION-1:0] gen_prn1,
   output logic [PRECISION-1:0] gen_prn2,
   output logic [PRECISION-1:0] gen_prn3,
   input  logic                 gen_valid,
   input  logic [7:0]           gen_v,
   output logic                 sbox_we,
   output logic [7:0]           sbox_waddr,
   output logic [7:0]           sbox_wdata,
   output logic                 busy,
   output logic                 done,
   output logic [8:0]           fill_count,
   output logic [CNT_W-1:0]     reject_count
);

   typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FILL, ST_DONE} state_t;

   state_t               r_state, w_next;
   logic [255:0]         r_used;
   logic [CNT_W-1:0]     r_draws, r_rej;
   logic [4:0]           r_outst;
   logic [7:0]           r_scan, r_waddr, r_wdata;
   logic [8:0]           r_fill;
   logic                 r_tvalid, r_we;
   logic [PRECISION-1:0] r_prn1, r_prn2, r_prn3;

   logic       w_clear, w_issue, w_ret, w_accept, w_reject, w_fill_wr, w_full, w_draws_max;
   logic [7:0] w_wval;

   assign w_full      = r_fill[8];
   assign w_draws_max = (r_draws == CNT_W'(MAX_DRAWS));
   assign w_wval      = w_fill_wr ? r_scan : gen_v;

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_clear   = 1'b0;
      w_issue   = 1'b0;
      w_ret     = 1'b0;
      w_fill_wr = 1'b0;
      unique case (r_state)
         ST_IDLE: if (start) begin
            w_clear = 1'b1;
            w_next  = ST_RUN;
         end
         ST_RUN: begin
            w_ret = gen_valid;
            if (w_full || w_draws_max) w_next  = ST_DRAIN;
            else                       w_issue = prn_valid;
         end
         ST_DRAIN: begin
            w_ret = gen_valid;
            if (r_outst == 5'd0) w_next = w_full ? ST_DONE : ST_FILL;
         end
         ST_FILL: begin
            if (w_full) w_next    = ST_DONE;
            else        w_fill_wr = ~r_used[r_scan];
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      // Results arriving once the table is full are dropped without counting.
      w_accept = w_ret & ~w_full & ~r_used[gen_v];
      w_reject = w_ret & ~w_full &  r_used[gen_v];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tvalid <= 1'b0;
         r_we     <= 1'b0;
         r_prn1   <= '0;
         r_prn2   <= '0;
         r_prn3   <= '0;
         r_used   <= '0;
         r_fill   <= '0;
         r_draws  <= '0;
         r_rej    <= '0;
         r_outst  <= '0;
         r_scan   <= '0;
         r_waddr  <= '0;
         r_wdata  <= '0;
      end else begin
         r_tvalid <= w_issue;
         r_we     <= w_accept | w_fill_wr;
         if (w_issue) begin
            r_prn1 <= prn1;
            r_prn2 <= prn2;
            r_prn3 <= prn3;
         end
         if (w_clear) begin
            r_used  <= '0;
            r_fill  <= '0;
            r_draws <= '0;
            r_rej   <= '0;
            r_outst <= '0;
            r_scan  <= '0;
         end else begin
            r_outst <= r_outst + {4'd0, w_issue} - {4'd0, w_ret};
            if (w_issue) r_draws <= r_draws + CNT_W'(1);
            if (w_accept || w_fill_wr) begin
               r_used[w_wval] <= 1'b1;
               r_waddr        <= r_fill[7:0];
               r_wdata        <= w_wval;
               r_fill         <= r_fill + 9'd1;
            end
            if (w_reject && (r_rej != '1)) r_rej <= r_rej + CNT_W'(1);
            if (r_state == ST_FILL) r_scan <= r_scan + 8'd1;
         end
      end
   end

   assign gen_tvalid   = r_tvalid;
   assign gen_prn1     = r_prn1;
   assign gen_prn2     = r_prn2;
   assign gen_prn3     = r_prn3;
   assign sbox_we      = r_we;
   assign sbox_waddr   = r_waddr;
   assign sbox_wdata   = r_wdata;
   assign busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_FILL);
   assign done         = (r_state == ST_DONE);
   assign fill_count   = r_fill;
   assign reject_count = r_rej;

endmodule

// File: tb/tb_sbox_build_ctrl.sv
// Bench for sbox_build_ctrl: two instances (large and small draw budget) share stimulus;
// a latency-4 generator stub answers issues and a build-level model checks every cycle.
module tb_sbox_build_ctrl;
   localparam int unsigned PW = 32, CW = 16, MAXA = 4096, MAXB = 64, LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, start_a, start_b, prn_valid, gen_valid;
   logic [PW-1:0] prn1, prn2, prn3;
   logic [7:0]    gen_v;

   logic          tv_a, we_a, busy_a, done_a, tv_b, we_b, busy_b, done_b;
   logic [PW-1:0] p1_a, p2_a, p3_a, p1_b, p2_b, p3_b;
   logic [7:0]    wa_a, wd_a, wa_b, wd_b;
   logic [8:0]    fc_a, fc_b;
   logic [CW-1:0] rc_a, rc_b;

   sbox_build_ctrl #(.PRECISION(PW), .MAX_DRAWS(MAXA), .CNT_W(CW)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .prn_valid(prn_valid),
      .prn1(prn1), .prn2(prn2), .prn3(prn3), .gen_tvalid(tv_a),
      .gen_prn1(p1_a), .gen_prn2(p2_a), .gen_prn3(p3_a),
      .gen_valid(gen_valid), .gen_v(gen_v), .sbox_we(we_a), .sbox_waddr(wa_a),
      .sbox_wdata(wd_a), .busy(busy_a), .done(done_a), .fill_count(fc_a), .reject_count(rc_a));

   sbox_build_ctrl #(.PRECISION(PW), .MAX_DRAWS(MAXB), .CNT_W(CW)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .prn_valid(prn_valid),
      .prn1(prn1), .prn2(prn2), .prn3(prn3), .gen_tvalid(tv_b),
      .gen_prn1(p1_b), .gen_prn2(p2_b), .gen_prn3(p3_b),
      .gen_valid(gen_valid), .gen_v(gen_v), .sbox_we(we_b), .sbox_waddr(wa_b),
      .sbox_wdata(wd_b), .busy(busy_b), .done(done_b), .fill_count(fc_b), .reject_count(rc_b));

   // Selected instance view
   logic          sel;
   logic          s_start, s_tv, s_we, s_busy, s_done;
   logic [PW-1:0] s_p1, s_p2, s_p3;
   logic [7:0]    s_wa, s_wd;
   logic [8:0]    s_fc;
   logic [CW-1:0] s_rc;
   assign s_start = sel ? start_b : start_a;
   assign s_tv    = sel ? tv_b    : tv_a;
   assign s_we    = sel ? we_b    : we_a;
   assign s_busy  = sel ? busy_b  : busy_a;
   assign s_done  = sel ? done_b  : done_a;
   assign s_p1    = sel ? p1_b    : p1_a;
   assign s_p2    = sel ? p2_b    : p2_a;
   assign s_p3    = sel ? p3_b    : p3_a;
   assign s_wa    = sel ? wa_b    : wa_a;
   assign s_wd    = sel ? wd_b    : wd_a;
   assign s_fc    = sel ? fc_b    : fc_a;
   assign s_rc    = sel ? rc_b    : rc_a;

   int tests = 0, fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   int unsigned cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Generator stub: answers each issue LAT cycles later; value depends on mode.
   int          mode;
   int unsigned iss_idx;
   int unsigned due_q[$];
   logic [7:0]  val_q[$];
   initial begin
      logic [7:0] v;
      gen_valid = 1'b0;
      gen_v     = 8'h00;
      forever begin
         @(negedge clk);
         gen_valid = 1'b0;
         if (s_tv) begin
            case (mode)
               0:       v = 8'(iss_idx);
               1:       v = 8'h5A;
               default: v = (iss_idx == 0) ? 8'h10 : (iss_idx == 1) ? 8'h10 :
                            (iss_idx == 2) ? 8'h11 : 8'(8'h20 + iss_idx);
            endcase
            due_q.push_back(cyc + LAT - 1);
            val_q.push_back(v);
            iss_idx++;
         end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            gen_valid = 1'b1;
            gen_v     = val_q[0];
            void'(due_q.pop_front());
            void'(val_q.pop_front());
         end
      end
   end

   // Build-level model and per-cycle compare
   typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_FILL, M_DONE} mph_t;
   mph_t          ph = M_IDLE;
   bit            used[256];
   int unsigned   fillq[$];
   int unsigned   m_fill = 0, m_rej = 0, m_out = 0, m_draws = 0, fill_cyc = 0;
   logic [7:0]    mem[256];
   int unsigned   wr_cnt = 0, tv_cnt = 0, last_wr_cyc = 0, done_cyc = 0;
   bit            done_seen = 0;

   initial begin : model
      int unsigned f0, o0, d0, mmax;
      logic        e_tv, e_we, fill_slot;
      logic [7:0]  e_addr, e_data;
      logic [PW-1:0] e_p1, e_p2, e_p3;
      forever begin
         @(posedge clk);
         #1;
         e_tv = 0; e_we = 0; e_addr = 0; e_data = 0; fill_slot = 0;
         e_p1 = '0; e_p2 = '0; e_p3 = '0;
         mmax = sel ? MAXB : MAXA;
         f0 = m_fill; o0 = m_out; d0 = m_draws;
         if (!reset_n) begin
            ph = M_IDLE; m_fill = 0; m_rej = 0; m_out = 0; m_draws = 0;
            fillq.delete();
            foreach (used[i]) used[i] = 1'b0;
         end else begin
            case (ph)
               M_IDLE: if (s_start) begin
                  foreach (used[i]) used[i] = 1'b0;
                  m_fill = 0; m_rej = 0; m_out = 0; m_draws = 0;
                  ph = M_RUN;
               end
               M_RUN, M_DRAIN: begin
                  if (gen_valid) begin
                     m_out--;
                     if (f0 < 256) begin
                        if (!used[gen_v]) begin
                           e_we = 1; e_addr = 8'(f0); e_data = gen_v;
                           used[gen_v] = 1'b1;
                           m_fill++;
                        end else if (m_rej < (1 << CW) - 1) m_rej++;
                     end
                  end
                  if (ph == M_RUN) begin
                     if (f0 == 256 || d0 == mmax) ph = M_DRAIN;
                     else if (prn_valid) begin
                        e_tv = 1; e_p1 = prn1; e_p2 = prn2; e_p3 = prn3;
                        m_out++; m_draws++;
                     end
                  end else if (o0 == 0) begin
                     if (f0 == 256) ph = M_DONE;
                     else begin
                        for (int unsigned v = 0; v < 256; v++) if (!used[v]) fillq.push_back(v);
                        fill_cyc = 0;
                        ph = M_FILL;
                     end
                  end
               end
               M_FILL: if (fillq.size() == 0) ph = M_DONE; else fill_slot = 1;
               M_DONE: ph = M_IDLE;
               default: ph = M_IDLE;
            endcase
         end

         chk("gen_tvalid", 32'(s_tv), 32'(e_tv));
         if (e_tv) begin
            chk("gen_prn1", s_p1, e_p1);
            chk("gen_prn2", s_p2, e_p2);
            chk("gen_prn3", s_p3, e_p3);
         end
         if (fill_slot) begin
            fill_cyc++;
            if (fill_cyc == 257) chk("fill_scan_bound", 32'(fill_cyc), 32'd256);
            if (s_we) begin
               chk("fill_addr", 32'(s_wa), 32'(f0 & 255));
               chk("fill_data", 32'(s_wd), fillq[0]);
               used[fillq[0]] = 1'b1;
               void'(fillq.pop_front());
               m_fill++;
            end
         end else begin
            chk("sbox_we", 32'(s_we), 32'(e_we));
            if (e_we) begin
               chk("sbox_waddr", 32'(s_wa), 32'(e_addr));
               chk("sbox_wdata", 32'(s_wd), 32'(e_data));
            end
         end
         chk("busy", 32'(s_busy), 32'(ph == M_RUN || ph == M_DRAIN || ph == M_FILL));
         chk("done", 32'(s_done), 32'(ph == M_DONE));
         chk("fill_count", 32'(s_fc), m_fill);
         chk("reject_count", 32'(s_rc), m_rej);
         chk("other_idle", sel ? {29'd0, we_a, busy_a, tv_a} : {29'd0, we_b, busy_b, tv_b}, 32'd0);

         if (s_we) begin mem[s_wa] = s_wd; wr_cnt++; last_wr_cyc = cyc; end
         if (s_tv) tv_cnt++;
         if (s_done) begin done_seen = 1; done_cyc = cyc; end
      end
   end

   task automatic set_prn(input int unsigned k);
      prn1 = 32'hC0DE_0000 ^ k;
      prn2 = k * 7;
      prn3 = ~k;
   endtask

   task automatic clear_log();
      wr_cnt = 0; tv_cnt = 0; done_seen = 0; iss_idx = 0;
      foreach (mem[i]) mem[i] = 8'h00;
   endtask

   task automatic build(input logic which, input int md, input int pulse_at);
      sel = which; mode = md;
      clear_log();
      prn_valid = 1'b1;
      set_prn(0);
      if (which) start_b = 1'b1; else start_a = 1'b1;
      for (int k = 1; k < 3000 && !done_seen; k++) begin
         @(negedge clk);
         start_a = 1'b0; start_b = 1'b0;
         if (k == pulse_at) begin
            if (which) start_b = 1'b1; else start_a = 1'b1;
         end
         set_prn(k);
      end
      start_a = 1'b0; start_b = 1'b0;
      prn_valid = 1'b0;
      if (!done_seen) chk("build_timeout", 32'(done_seen), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad, w0;
      logic [7:0] e;
      reset_n = 0; start_a = 0; start_b = 0; prn_valid = 0; sel = 0; mode = 0;
      set_prn(0);
      repeat (3) @(negedge clk);
      chk("rst_a_outputs", {24'd0, tv_a, we_a, busy_a, done_a, 4'd0}, 32'd0);
      chk("rst_b_counts", {7'd0, fc_b, rc_b}, 32'd0);
      reset_n = 1;
      @(negedge clk);

      // Identity generator, with a start pulse ignored mid-run
      build(1'b0, 0, 20);
      chk("id_fill_count", 32'(fc_a), 32'd256);
      chk("id_reject_count", 32'(rc_a), 32'd0);
      chk("id_writes", wr_cnt, 32'd256);
      bad = 0;
      for (int k = 0; k < 256; k++) if (mem[k] != 8'(k)) bad++;
      chk("id_table_map", 32'(bad), 32'd0);
      chk("id_issue_range", 32'(tv_cnt >= 256 && tv_cnt <= 262), 32'd1);
      chk("id_done_after_write", 32'(done_cyc > last_wr_cyc), 32'd1);

      // Constant generator on the 64-draw instance: one hit, then ascending fill
      build(1'b1, 1, 0);
      chk("k_fill_count", 32'(fc_b), 32'd256);
      chk("k_reject_count", 32'(rc_b), 32'd63);
      chk("k_issues", tv_cnt, 32'd64);
      chk("k_addr0", 32'(mem[0]), 32'h5A);
      chk("k_addr5a", 32'(mem[8'h5A]), 32'h59);
      chk("k_addr5b", 32'(mem[8'h5B]), 32'h5B);
      chk("k_addrff", 32'(mem[255]), 32'hFF);
      bad = 0;
      for (int k = 0; k < 256; k++) begin
         e = (k == 0) ? 8'h5A : (k <= 8'h5A) ? 8'(k - 1) : 8'(k);
         if (mem[k] != e) bad++;
      end
      chk("k_table_map", 32'(bad), 32'd0);
      chk("k_done_latency", done_cyc - last_wr_cyc, 32'd1);

      // Short sequence 0x10,0x10,0x11
      sel = 0; mode = 2;
      clear_log();
      start_a = 1;
      @(negedge clk);
      start_a = 0;
      prn_valid = 1;
      for (int k = 0; k < 3; k++) begin
         set_prn(100 + k);
         @(negedge clk);
      end
      prn_valid = 0;
      repeat (10) @(negedge clk);
      chk("seq_fill_count", 32'(fc_a), 32'd2);
      chk("seq_reject_count", 32'(rc_a), 32'd1);
      chk("seq_addr0", 32'(mem[0]), 32'h10);
      chk("seq_addr1", 32'(mem[1]), 32'h11);
      chk("seq_busy", 32'(busy_a), 32'd1);

      // Reset while three draws are outstanding; their late results must be ignored
      prn_valid = 1;
      for (int k = 0; k < 3; k++) begin
         set_prn(200 + k);
         @(negedge clk);
      end
      prn_valid = 0;
      reset_n = 0;
      @(negedge clk);
      chk("rst_mid_flags", {28'd0, tv_a, we_a, busy_a, done_a}, 32'd0);
      chk("rst_mid_counts", {7'd0, fc_a, rc_a}, 32'd0);
      chk("rst_mid_write_bus", {16'd0, wa_a, wd_a}, 32'd0);
      chk("rst_mid_prn", p1_a | p2_a | p3_a, 32'd0);
      reset_n = 1;
      w0 = int'(wr_cnt);
      repeat (12) @(negedge clk);
      chk("no_write_after_reset", wr_cnt, 32'(w0));
      chk("idle_after_reset", 32'(busy_a), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
